// File: rtl/hack_gpio_bank_if.sv
// Hack data-bus view of the GPIO bank: addressM/writeM/outM in, inM contribution and window hit out.
interface hack_gpio_bus_if #(
    parameter int ADDRESS_WIDTH = 15,
    parameter int WORD_WIDTH    = 16
);
    logic                     bus_strobe;
    logic [ADDRESS_WIDTH-1:0] bus_address;
    logic                     bus_write;
    logic [WORD_WIDTH-1:0]    bus_wdata;
    logic [WORD_WIDTH-1:0]    bus_rdata;
    logic                     bus_hit;

    modport master (
        output bus_strobe, bus_address, bus_write, bus_wdata,
        input  bus_rdata, bus_hit
    );

    modport slave (
        input  bus_strobe, bus_address, bus_write, bus_wdata,
        output bus_rdata, bus_hit
    );
endinterface

// File: rtl/hack_gpio_bank.sv
// Multi-channel memory-mapped GPIO for the Hack SoC: per-channel OUT/DIR/IN/EDGE registers,
// synchronised pad inputs, sticky rising-edge capture and a combined registered interrupt.
module hack_gpio_chan #(
    parameter int WORD_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  soft_reset_i,
    input  logic                  wr_out_i,
    input  logic                  wr_dir_i,
    input  logic                  wr_edge_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic [WORD_WIDTH-1:0] pin_i,
    output logic [WORD_WIDTH-1:0] out_o,
    output logic [WORD_WIDTH-1:0] dir_o,
    output logic [WORD_WIDTH-1:0] in_o,
    output logic [WORD_WIDTH-1:0] edge_o
);
    logic [SYNC_STAGES-1:0][WORD_WIDTH-1:0] sync_q;
    logic [WORD_WIDTH-1:0] prev_q;
    logic [WORD_WIDTH-1:0] out_q, out_d;
    logic [WORD_WIDTH-1:0] dir_q, dir_d;
    logic [WORD_WIDTH-1:0] edge_q, edge_d;
    logic [WORD_WIDTH-1:0] in_w, rise_w;

    assign in_w   = sync_q[SYNC_STAGES-1];
    assign rise_w = in_w & ~prev_q & ~dir_q;

    // Set is OR-ed in after the clear so a coincident rise survives the W1C write.
    always_comb begin
        out_d  = wr_out_i ? wdata_i : out_q;
        dir_d  = wr_dir_i ? wdata_i : dir_q;
        edge_d = (edge_q & ~(wr_edge_i ? wdata_i : '0)) | rise_w;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
            out_q  <= '0;
            dir_q  <= '0;
            edge_q <= '0;
        end else begin
            // Synchroniser and prev keep running through soft reset to avoid false edges.
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= in_w;
            if (soft_reset_i) begin
                out_q  <= '0;
                dir_q  <= '0;
                edge_q <= '0;
            end else begin
                out_q  <= out_d;
                dir_q  <= dir_d;
                edge_q <= edge_d;
            end
        end
    end

    assign out_o  = out_q;
    assign dir_o  = dir_q;
    assign in_o   = in_w;
    assign edge_o = edge_q;
endmodule

module hack_gpio_bank #(
    parameter int WORD_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 15,
    parameter int BASE_ADDRESS  = 24577,
    parameter int CHANNELS      = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           soft_reset,
    hack_gpio_bus_if.slave                 bus,
    input  logic [CHANNELS*WORD_WIDTH-1:0] gpio_i,
    output logic [CHANNELS*WORD_WIDTH-1:0] gpio_o,
    output logic [CHANNELS*WORD_WIDTH-1:0] gpio_oe,
    output logic                           irq
);
    // One extra bit so a window near the top of the address space cannot wrap to zero.
    localparam int OW = ADDRESS_WIDTH + 1;
    localparam logic [OW-1:0] BASE_X = OW'(BASE_ADDRESS);
    localparam logic [OW-1:0] END_X  = OW'(BASE_ADDRESS + 4*CHANNELS);

    logic [OW-1:0] addr_x, off_w;
    logic [OW-3:0] off_ch;
    logic [1:0]    off_reg;
    logic          hit_w, wr_qual;
    logic [CHANNELS-1:0][WORD_WIDTH-1:0] out_w, dir_w, in_w, edge_w, pin_w;
    logic [WORD_WIDTH-1:0] rdata_w;
    logic irq_q, irq_d;

    assign addr_x  = {1'b0, bus.bus_address};
    assign hit_w   = (addr_x >= BASE_X) && (addr_x < END_X);
    assign off_w   = addr_x - BASE_X;
    assign off_ch  = off_w[OW-1:2];
    assign off_reg = off_w[1:0];
    assign wr_qual = bus.bus_strobe && bus.bus_write && hit_w;
    assign pin_w   = gpio_i;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic sel;
        assign sel = wr_qual && (int'(off_ch) == c);

        hack_gpio_chan #(
            .WORD_WIDTH  (WORD_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk          (clk),
            .reset_n      (reset_n),
            .soft_reset_i (soft_reset),
            .wr_out_i     (sel && (off_reg == 2'd0)),
            .wr_dir_i     (sel && (off_reg == 2'd1)),
            .wr_edge_i    (sel && (off_reg == 2'd3)),
            .wdata_i      (bus.bus_wdata),
            .pin_i        (pin_w[c]),
            .out_o        (out_w[c]),
            .dir_o        (dir_w[c]),
            .in_o         (in_w[c]),
            .edge_o       (edge_w[c])
        );
    end

    always_comb begin
        rdata_w = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (hit_w && (int'(off_ch) == c)) begin
                case (off_reg)
                    2'd0:    rdata_w = out_w[c];
                    2'd1:    rdata_w = dir_w[c];
                    2'd2:    rdata_w = in_w[c];
                    default: rdata_w = edge_w[c];
                endcase
            end
        end
    end

    assign irq_d = |edge_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        irq_q <= 1'b0;
        else if (soft_reset) irq_q <= 1'b0;
        else                 irq_q <= irq_d;
    end

    assign bus.bus_rdata = rdata_w;
    assign bus.bus_hit   = hit_w;
    assign gpio_o        = out_w;
    assign gpio_oe       = dir_w;
    assign irq           = irq_q;
endmodule

// File: tb/tb_hack_gpio_bank.sv
module tb_hack_gpio_bank;
    localparam int W    = 16;
    localparam int AW   = 15;
    localparam int CH   = 2;
    localparam int S    = 2;
    localparam int BASE = 24577;

    logic clk = 1'b0;
    logic reset_n, soft_reset;
    logic [CH*W-1:0] gpio_i, gpio_o, gpio_oe;
    logic irq;

    hack_gpio_bus_if #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(W)) bus ();

    hack_gpio_bank #(
        .WORD_WIDTH(W), .ADDRESS_WIDTH(AW), .BASE_ADDRESS(BASE),
        .CHANNELS(CH), .SYNC_STAGES(S)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .soft_reset (soft_reset),
        .bus        (bus),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_oe    (gpio_oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [63:0] exp;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0]    m_out[CH], m_dir[CH], m_edge[CH], m_prev[CH];
    logic            m_irq;
    logic [CH*W-1:0] hist[$];

    function automatic string kname(int k);
        case (k)
            0: return "rdata";
            1: return "hit";
            2: return "gpio_o";
            3: return "gpio_oe";
            default: return "irq";
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t c;
            logic [63:0] act;
            c = sb.pop_front();
            case (c.kind)
                0: act = 64'(bus.bus_rdata);
                1: act = 64'(bus.bus_hit);
                2: act = 64'(gpio_o);
                3: act = 64'(gpio_oe);
                default: act = 64'(irq);
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s t=%0t actual=%h expected=%h", kname(c.kind), $time, act, c.exp);
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout t=%0t: sequence did not finish", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic chk_reset(string tag);
        checks++;
        if (gpio_o !== '0 || gpio_oe !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset(%s) t=%0t gpio_o=%h gpio_oe=%h irq=%b", tag, $time, gpio_o, gpio_oe, irq);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_out[c] = '0; m_dir[c] = '0; m_edge[c] = '0; m_prev[c] = '0;
        end
        m_irq = 1'b0;
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back('0);
    endtask

    function automatic bit in_win(int a);
        return (a >= BASE) && (a < BASE + 4*CH);
    endfunction

    task automatic push(int k, logic [63:0] e);
        chk_t c;
        c.kind = k; c.exp = e;
        sb.push_back(c);
    endtask

    task automatic model_step();
        logic [W-1:0]    n_out[CH], n_dir[CH], n_edge[CH], clr, cur;
        logic [CH*W-1:0] h0;
        logic            n_irq;
        int              a, off;
        bit              qual;
        if (!reset_n) begin
            model_reset();
            return;
        end
        a    = int'(bus.bus_address);
        qual = bus.bus_strobe && bus.bus_write && in_win(a);
        off  = a - BASE;
        h0   = hist[0];
        n_irq = 1'b0;
        for (int c = 0; c < CH; c++) n_irq |= (m_edge[c] != 0);
        for (int c = 0; c < CH; c++) begin
            cur = h0[c*W +: W];
            n_out[c] = m_out[c];
            n_dir[c] = m_dir[c];
            clr = '0;
            if (qual && (off / 4 == c)) begin
                case (off % 4)
                    0: n_out[c] = bus.bus_wdata;
                    1: n_dir[c] = bus.bus_wdata;
                    3: clr = bus.bus_wdata;
                    default: ;
                endcase
            end
            n_edge[c] = (m_edge[c] & ~clr) | (cur & ~m_prev[c] & ~m_dir[c]);
            m_prev[c] = cur;
        end
        if (soft_reset) begin
            for (int c = 0; c < CH; c++) begin
                n_out[c] = '0; n_dir[c] = '0; n_edge[c] = '0;
            end
            n_irq = 1'b0;
        end
        m_out = n_out; m_dir = n_dir; m_edge = n_edge; m_irq = n_irq;
        void'(hist.pop_front());
        hist.push_back(gpio_i);
    endtask

    task automatic push_outputs();
        logic [CH*W-1:0] o, oe;
        for (int c = 0; c < CH; c++) begin
            o[c*W +: W]  = m_out[c];
            oe[c*W +: W] = m_dir[c];
        end
        push(2, 64'(o));
        push(3, 64'(oe));
        push(4, 64'(m_irq));
    endtask

    task automatic cyc();
        int          a, off;
        logic [W-1:0] rd;
        logic [CH*W-1:0] h0;
        a  = int'(bus.bus_address);
        rd = '0;
        if (in_win(a)) begin
            off = a - BASE;
            h0  = hist[0];
            case (off % 4)
                0: rd = m_out[off/4];
                1: rd = m_dir[off/4];
                2: rd = h0[(off/4)*W +: W];
                default: rd = m_edge[off/4];
            endcase
        end
        push(0, 64'(rd));
        push(1, 64'(in_win(a)));
        push_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(int a);
        bus.bus_address = AW'(a);
        bus.bus_write = 1'b0;
        bus.bus_strobe = 1'b0;
        cyc();
    endtask

    task automatic wr(int a, logic [W-1:0] d, logic stb);
        bus.bus_address = AW'(a);
        bus.bus_wdata = d;
        bus.bus_write = 1'b1;
        bus.bus_strobe = stb;
        cyc();
        bus.bus_write = 1'b0;
        bus.bus_strobe = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; soft_reset = 1'b0; gpio_i = '0;
        bus.bus_strobe = 1'b0; bus.bus_address = '0; bus.bus_write = 1'b0; bus.bus_wdata = '0;
        model_reset();
        #1;
        cyc(); cyc();
        chk_reset("power-on");
        reset_n = 1'b1;

        for (int a = BASE - 1; a <= BASE + 8; a++) rd(a);

        wr(BASE + 1, 16'h00FF, 1'b1);
        wr(BASE + 0, 16'hA5A5, 1'b1);
        rd(BASE + 0);
        wr(BASE + 1, 16'h1234, 1'b0);
        wr(BASE + 0, 16'h5A5A, 1'b0);
        rd(BASE + 1);

        gpio_i[31:16] = 16'h8001;
        for (int i = 0; i < 3; i++) rd(BASE + 6);
        for (int i = 0; i < 3; i++) rd(BASE + 7);

        wr(BASE + 7, 16'h0001, 1'b1);
        rd(BASE + 7);
        wr(BASE + 7, 16'h8000, 1'b1);
        rd(BASE + 7); rd(BASE + 7);

        gpio_i[16] = 1'b0;
        for (int i = 0; i < 4; i++) rd(BASE + 7);
        gpio_i[16] = 1'b1;
        rd(BASE + 7); rd(BASE + 7);
        wr(BASE + 7, 16'h0001, 1'b1);
        rd(BASE + 7); rd(BASE + 7);

        wr(BASE + 1, 16'h0008, 1'b1);
        gpio_i[3] = 1'b0;
        for (int i = 0; i < 3; i++) rd(BASE + 3);
        gpio_i[3] = 1'b1;
        for (int i = 0; i < 4; i++) rd(BASE + 3);
        wr(BASE + 1, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) rd(BASE + 3);

        soft_reset = 1'b1;
        wr(BASE + 0, 16'hFFFF, 1'b1);
        soft_reset = 1'b0;
        rd(BASE + 0); rd(BASE + 3);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) gpio_i = CH*W'($urandom());
            soft_reset = ($urandom_range(0, 40) == 0);
            case ($urandom_range(0, 9))
                0:       bus.bus_address = AW'($urandom_range(0, 32767));
                1:       bus.bus_address = 15'h7FFF;
                default: bus.bus_address = AW'(BASE - 2 + int'($urandom_range(0, 4*CH + 3)));
            endcase
            bus.bus_write  = $urandom_range(0, 1) == 1;
            bus.bus_strobe = $urandom_range(0, 2) != 0;
            bus.bus_wdata  = W'($urandom());
            cyc();
        end
        soft_reset = 1'b0;
        bus.bus_write = 1'b0;
        bus.bus_strobe = 1'b0;

        wr(BASE + 0, 16'hFFFF, 1'b1);
        wr(BASE + 1, 16'hFFFF, 1'b1);
        wr(BASE + 5, 16'h0000, 1'b1);
        gpio_i = '0;
        for (int i = 0; i < 4; i++) rd(BASE + 7);
        gpio_i = '1;
        for (int i = 0; i < 5; i++) rd(BASE + 0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_reset("async");
        push_outputs();
        cyc(); cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) rd(BASE + 7);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hack_gpio_bank.md
Name: hack_gpio_bank

Overview:
Parametrised memory-mapped GPIO peripheral for the Hack SoC. It supersedes the single write-only GPIO word with CHANNELS independent ports. Each port has an output register, a per-bit direction register, synchronised pin inputs and sticky rising-edge capture. The bank sits on the Hack data bus (addressM/writeM/outM/inM) in the I/O window after the keyboard register. A combined interrupt line is provided for future CPU use.

Parameters:
- WORD_WIDTH, 16, data width of each channel and of the bus.
- ADDRESS_WIDTH, 15, Hack addressM width.
- BASE_ADDRESS, 24577 (0x6001), address of channel 0 OUT register.
- CHANNELS, 2, number of GPIO ports, 1..8.
- SYNC_STAGES, 2, input synchroniser depth, >=2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous clear; driven from hack_reset.
- bus_strobe  in  1  one-cycle qualifier, high on the clk cycle of the hack_clk rising edge.
- bus_address  in  ADDRESS_WIDTH  Hack addressM.
- bus_write  in  1  Hack writeM.
- bus_wdata  in  WORD_WIDTH  Hack outM.
- bus_rdata  out  WORD_WIDTH  read data, muxed into inM.
- bus_hit  out  1  address falls inside the bank window.
- gpio_i  in  CHANNELS*WORD_WIDTH  pad inputs, asynchronous; channel n occupies bits [n*WORD_WIDTH +: WORD_WIDTH].
- gpio_o  out  CHANNELS*WORD_WIDTH  pad output values.
- gpio_oe  out  CHANNELS*WORD_WIDTH  pad output enables, 1 = drive.
- irq  out  1  any enabled edge pending.

Behaviour:
- Register map (offset = bus_address - BASE_ADDRESS; ch = offset>>2, reg = offset[1:0]):
  - reg 0: OUT, read/write.
  - reg 1: DIR, read/write; 1 = output.
  - reg 2: IN, read-only; synchronised pins.
  - reg 3: EDGE, sticky rising-edge flags; write-1-to-clear.
- Address decode and read path:
  - bus_hit = (bus_address >= BASE_ADDRESS) && (bus_address < BASE_ADDRESS + 4*CHANNELS), combinational.
  - bus_rdata is combinational from registered state. It is 0 when bus_hit=0.
  - Reads have no side effects.
- Writes:
  - Committed on the rising clk edge where bus_strobe && bus_write && bus_hit.
  - Writes to IN are ignored.
  - Writes outside the window are ignored.
  - No write occurs without bus_strobe, even if bus_write=1.
- Outputs: gpio_o = OUT registers, gpio_oe = DIR registers, both registered with zero combinational path from the bus.
- Input path: each bit passes through a SYNC_STAGES flop chain. IN = final stage, so pin-to-IN latency is SYNC_STAGES clk cycles.
- Edge detection:
  - prev = IN delayed one cycle.
  - rise = IN & ~prev & ~DIR. Output-configured bits never capture.
  - EDGE[b] sets on rise[b]. It clears on a qualified write with wdata[b]=1.
  - If set and clear hit the same bit in the same cycle, set wins.
- irq = OR over all channels of EDGE, registered. It rises one cycle after the EDGE bit sets.
- Asynchronous reset (reset_n=0): OUT, DIR, EDGE, synchroniser chains, prev and irq all go to 0, so all pins are inputs and gpio_o=0.
- soft_reset=1 at a clk edge:
  - Clears OUT, DIR, EDGE and irq.
  - Synchronisers and prev keep running, so no false edge is seen on release.
  - soft_reset beats a simultaneous bus write.
- DIR change 1->0 while pin is high: prev already tracks IN, so no edge is captured unless the pin later rises.
- Address wrap: the window end is computed at ADDRESS_WIDTH+1 bits. A BASE_ADDRESS near the top of the space must not alias to low addresses.
- No internal state machine beyond the register and edge logic. All behaviour is single-cycle, with the latencies stated above.

Test Plan:
- Reset, then read 0x6001..0x6008 → all 0. gpio_oe=0, irq=0, bus_hit=1 on 0x6001..0x6008, bus_hit=0 on 0x6000 and 0x6009.
- Write DIR ch0 (0x6002) = 0x00FF, then OUT ch0 (0x6001) = 0xA5A5, each with bus_strobe → gpio_oe[15:0]=0x00FF and gpio_o[15:0]=0xA5A5 the cycle after. Repeat the writes with bus_strobe=0 → no change.
- Drive gpio_i[31:16]=0x8001 with DIR ch1=0 → IN ch1 (0x6007) reads 0x8001 after exactly 2 cycles. EDGE ch1 (0x6008) reads 0x8001 and irq=1 one cycle later.
- Write 0x0001 to 0x6008 → EDGE ch1=0x8000, irq stays 1. Write 0x8000 → EDGE=0, irq=0. Re-run with a new rise on bit 0 coincident with the clear write → EDGE bit 0 remains 1.
- Set DIR ch0 bit 3=1, toggle gpio_i[3] low→high → EDGE ch0 bit 3 stays 0.
- Pulse soft_reset coincident with a write of 0xFFFF to 0x6001 → OUT=0. Assert reset_n=0 mid-sequence without clk → all outputs 0 immediately.
